// File: rtl/fanctrl_pkg.sv
// Shared constants and state codes for the fan controller configuration path.
// Latency: none (declarations only).
// Backpressure: none; the byte bus is strobe-only with no ready signal.
package fanctrl_pkg;

    // Frame framing
    localparam logic [7:0] FRAME_HEADER  = 8'hA5;
    localparam int         PAYLOAD_BYTES = 23;

    // Payload byte counter: 0..22, plus one spare code
    localparam int                CNT_W            = 5;
    localparam logic [CNT_W-1:0]  LAST_PAYLOAD_IDX = CNT_W'(PAYLOAD_BYTES - 1);

    // Payload map: five 4-byte coefficients, LSB first, then the PWM limits
    localparam int COEF_COUNT     = 5;
    localparam int COEF_BYTES     = 4;
    localparam int PERIOD_LSB_IDX = 20;
    localparam int PERIOD_MSB_IDX = 21;
    localparam int MIN_IDX        = 22;

    // One-hot state codes, exported directly on state_o
    typedef enum logic [3:0] {
        ST_IDLE    = 4'h1,
        ST_PAYLOAD = 4'h2,
        ST_CHECK   = 4'h4,
        ST_PENDING = 4'h8
    } cfg_state_t;

endpackage

// File: rtl/fan_config_loader_cfg_shadow_regs.sv
// Shadow byte bank for an incoming frame plus the active register bank it commits into.
// Latency: a shadow write lands at the strobe edge; commit_i updates active outputs on the next edge.
// Backpressure: none; every write/commit request is taken in the cycle it is presented.
module cfg_shadow_regs
    import fanctrl_pkg::*;
#(
    parameter int                      REG_BITWIDTH   = 32,
    parameter int                      ADC_BITWIDTH   = 8,
    parameter logic [ADC_BITWIDTH:0]   DEFAULT_PERIOD = 9'd255,
    parameter logic [ADC_BITWIDTH-1:0] DEFAULT_MIN    = 8'd0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [CNT_W-1:0]               wr_addr_i,
    input  logic [ADC_BITWIDTH-1:0]        wr_dat_i,
    input  logic                           commit_i,
    output logic [ADC_BITWIDTH:0]          shadow_period_o,
    output logic [ADC_BITWIDTH-1:0]        shadow_min_o,
    output logic signed [REG_BITWIDTH-1:0] a0_o,
    output logic signed [REG_BITWIDTH-1:0] a1_o,
    output logic signed [REG_BITWIDTH-1:0] b0_o,
    output logic signed [REG_BITWIDTH-1:0] b1_o,
    output logic signed [REG_BITWIDTH-1:0] b2_o,
    output logic [ADC_BITWIDTH:0]          period_o,
    output logic [ADC_BITWIDTH-1:0]        min_o
);

    logic [PAYLOAD_BYTES-1:0][ADC_BITWIDTH-1:0] shadow_q, shadow_d;

    logic [COEF_COUNT-1:0][REG_BITWIDTH-1:0] coef_q, coef_d;
    logic [ADC_BITWIDTH:0]                   period_q, period_d;
    logic [ADC_BITWIDTH-1:0]                 min_q, min_d;

    // Shadow coefficients reassembled from their little-endian byte slots
    logic [COEF_COUNT-1:0][REG_BITWIDTH-1:0] shadow_coef;

    genvar k;
    generate
        for (k = 0; k < COEF_COUNT; k++) begin : g_coef
            logic [8*COEF_BYTES-1:0] word;
            assign word = {shadow_q[COEF_BYTES*k+3], shadow_q[COEF_BYTES*k+2],
                           shadow_q[COEF_BYTES*k+1], shadow_q[COEF_BYTES*k]};
            // Coefficients are signed; widen or narrow by sign extension
            assign shadow_coef[k] = REG_BITWIDTH'(signed'(word));
        end
    endgenerate

    // Only bit 0 of the period MSB byte carries information
    assign shadow_period_o = {shadow_q[PERIOD_MSB_IDX][0], shadow_q[PERIOD_LSB_IDX]};
    assign shadow_min_o    = shadow_q[MIN_IDX];

    logic unused_period_msb_bits;
    assign unused_period_msb_bits = ^shadow_q[PERIOD_MSB_IDX][ADC_BITWIDTH-1:1];

    // Byte-addressed shadow write
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_i) begin
            shadow_d[wr_addr_i] = wr_dat_i;
        end
    end

    // Atomic copy of the whole shadow set into the active bank
    always_comb begin
        coef_d   = coef_q;
        period_d = period_q;
        min_d    = min_q;
        if (commit_i) begin
            coef_d   = shadow_coef;
            period_d = shadow_period_o;
            min_d    = shadow_min_o;
        end
    end

    // Shadow and active register state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            coef_q   <= '0;
            period_q <= DEFAULT_PERIOD;
            min_q    <= DEFAULT_MIN;
        end else begin
            shadow_q <= shadow_d;
            coef_q   <= coef_d;
            period_q <= period_d;
            min_q    <= min_d;
        end
    end

    assign a0_o     = coef_q[0];
    assign a1_o     = coef_q[1];
    assign b0_o     = coef_q[2];
    assign b1_o     = coef_q[3];
    assign b2_o     = coef_q[4];
    assign period_o = period_q;
    assign min_o    = min_q;

endmodule

// File: rtl/fan_config_loader.sv
// Byte-serial config frame parser: header/payload/checksum FSM feeding a shadow bank, committed on PID tick.
// Latency: checksum byte to active outputs is at least 2 cycles (PENDING entry, then first update_en_i).
// Backpressure: none; bytes arriving in IDLE (non-header) or PENDING are dropped.
module fan_config_loader
    import fanctrl_pkg::*;
#(
    parameter int                      REG_BITWIDTH   = 32,
    parameter int                      ADC_BITWIDTH   = 8,
    parameter logic [ADC_BITWIDTH:0]   DEFAULT_PERIOD = 9'd255,
    parameter logic [ADC_BITWIDTH-1:0] DEFAULT_MIN    = 8'd0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           config_en_i,
    input  logic                           dataVaild_STRB_i,
    input  logic [ADC_BITWIDTH-1:0]        data_i,
    input  logic                           update_en_i,
    output logic signed [REG_BITWIDTH-1:0] a0_o,
    output logic signed [REG_BITWIDTH-1:0] a1_o,
    output logic signed [REG_BITWIDTH-1:0] b0_o,
    output logic signed [REG_BITWIDTH-1:0] b1_o,
    output logic signed [REG_BITWIDTH-1:0] b2_o,
    output logic [ADC_BITWIDTH:0]          PWM_periodCounterValue_o,
    output logic [ADC_BITWIDTH-1:0]        PWM_minCounterValue_o,
    output logic                           busy_o,
    output logic                           commit_o,
    output logic                           error_o,
    output logic [3:0]                     state_o
);

    cfg_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADC_BITWIDTH-1:0] xor_q, xor_d;
    logic                    error_q, error_d;
    logic                    commit_q, commit_d;

    logic                    shadow_wr;
    logic                    commit_now;
    logic [ADC_BITWIDTH:0]   shadow_period;
    logic [ADC_BITWIDTH-1:0] shadow_min;
    logic                    limits_ok;

    // A frame whose floor exceeds its period would starve the PWM; reject it
    assign limits_ok = ({1'b0, shadow_min} <= shadow_period);

    // Next-state, counter, running checksum and status flags
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        xor_d      = xor_q;
        error_d    = error_q;
        commit_d   = 1'b0;
        shadow_wr  = 1'b0;
        commit_now = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dataVaild_STRB_i && config_en_i && (data_i == FRAME_HEADER)) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = '0;
                    xor_d   = '0;
                    error_d = 1'b0;
                end
            end
            ST_PAYLOAD: begin
                if (!config_en_i) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (dataVaild_STRB_i) begin
                    // 0xA5 here is ordinary data; there is no mid-frame resync
                    shadow_wr = 1'b1;
                    xor_d     = xor_q ^ data_i;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_PAYLOAD_IDX) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (!config_en_i) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (dataVaild_STRB_i) begin
                    if ((data_i == xor_q) && limits_ok) begin
                        state_d = ST_PENDING;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PENDING: begin
                // Verified frame waits for a PID tick; config_en_i no longer matters
                if (update_en_i) begin
                    commit_now = 1'b1;
                    commit_d   = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            xor_q    <= '0;
            error_q  <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            xor_q    <= xor_d;
            error_q  <= error_d;
            commit_q <= commit_d;
        end
    end

    cfg_shadow_regs #(
        .REG_BITWIDTH   (REG_BITWIDTH),
        .ADC_BITWIDTH   (ADC_BITWIDTH),
        .DEFAULT_PERIOD (DEFAULT_PERIOD),
        .DEFAULT_MIN    (DEFAULT_MIN)
    ) u_shadow (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .wr_en_i         (shadow_wr),
        .wr_addr_i       (cnt_q),
        .wr_dat_i        (data_i),
        .commit_i        (commit_now),
        .shadow_period_o (shadow_period),
        .shadow_min_o    (shadow_min),
        .a0_o            (a0_o),
        .a1_o            (a1_o),
        .b0_o            (b0_o),
        .b1_o            (b1_o),
        .b2_o            (b2_o),
        .period_o        (PWM_periodCounterValue_o),
        .min_o           (PWM_minCounterValue_o)
    );

    assign busy_o   = (state_q != ST_IDLE);
    assign commit_o = commit_q;
    assign error_o  = error_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_fan_config_loader.sv
// Bench for fan_config_loader: directed scenarios plus random frames against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fan_config_loader;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_i;
    logic        config_en_i;
    logic        strb;
    logic [7:0]  data_i;
    logic        update_en_i;
    logic signed [31:0] a0_o, a1_o, b0_o, b1_o, b2_o;
    logic [8:0]  period_o;
    logic [7:0]  min_o;
    logic        busy_o, commit_o, error_o;
    logic [3:0]  state_o;

    fan_config_loader dut (
        .clk_i                    (clk_i),
        .rst_i                    (rst_i),
        .config_en_i              (config_en_i),
        .dataVaild_STRB_i         (strb),
        .data_i                   (data_i),
        .update_en_i              (update_en_i),
        .a0_o                     (a0_o),
        .a1_o                     (a1_o),
        .b0_o                     (b0_o),
        .b1_o                     (b1_o),
        .b2_o                     (b2_o),
        .PWM_periodCounterValue_o (period_o),
        .PWM_minCounterValue_o    (min_o),
        .busy_o                   (busy_o),
        .commit_o                 (commit_o),
        .error_o                  (error_o),
        .state_o                  (state_o)
    );

    int total = 0;
    int bad   = 0;

    // Frame being sent
    logic [31:0] f_coef [5];
    logic [8:0]  f_period;
    logic [7:0]  f_min;
    logic [7:0]  pay [23];
    logic [7:0]  cks;

    // Model of the visible registers
    logic [31:0] m_coef [5];
    logic [8:0]  m_period;
    logic [7:0]  m_min;
    logic        exp_commit;
    logic        exp_err;
    logic        acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_coef[i] = 32'd0;
        m_period   = 9'd255;
        m_min      = 8'd0;
        exp_commit = 1'b0;
        exp_err    = 1'b0;
    endtask

    task automatic chk_outputs();
        chk("a0",     {32'd0, a0_o}, {32'd0, m_coef[0]});
        chk("a1",     {32'd0, a1_o}, {32'd0, m_coef[1]});
        chk("b0",     {32'd0, b0_o}, {32'd0, m_coef[2]});
        chk("b1",     {32'd0, b1_o}, {32'd0, m_coef[3]});
        chk("b2",     {32'd0, b2_o}, {32'd0, m_coef[4]});
        chk("period", 64'(period_o), 64'(m_period));
        chk("min",    64'(min_o),    64'(m_min));
        chk("commit", 64'(commit_o), 64'(exp_commit));
        chk("error",  64'(error_o),  64'(exp_err));
    endtask

    task automatic chk_state(input string tag, input logic [3:0] st);
        chk(tag, 64'(state_o), 64'(st));
        chk({tag, "_busy"}, 64'(busy_o), 64'(st != 4'h1));
    endtask

    // One clock: drive, wait for the edge, sample 1 time unit later
    task automatic cycle(input logic stb, input logic [7:0] d, input logic upd);
        strb        = stb;
        data_i      = d;
        update_en_i = upd;
        @(posedge clk_i);
        #1;
        strb        = 1'b0;
        update_en_i = 1'b0;
        chk_outputs();
    endtask

    // Idle cycles between bytes; ticks here must never cause a commit
    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'($urandom));
    endtask

    // Payload bytes and checksum straight from the frame fields
    task automatic build();
        for (int i = 0; i < 20; i++) pay[i] = f_coef[i / 4][8 * (i % 4) +: 8];
        pay[20] = f_period[7:0];
        pay[21] = {7'($urandom), f_period[8]};
        pay[22] = f_min;
        cks = 8'd0;
        for (int i = 0; i < 23; i++) cks = cks ^ pay[i];
    endtask

    task automatic send_frame(input logic corrupt, input logic tick_on_ck, output logic ok);
        exp_err = 1'b0;
        cycle(1'b1, 8'hA5, 1'b0);
        chk_state("hdr_state", 4'h2);
        for (int i = 0; i < 23; i++) begin
            gap();
            cycle(1'b1, pay[i], 1'b0);
        end
        chk_state("check_state", 4'h4);
        gap();
        ok = !corrupt && ({1'b0, f_min} <= f_period);
        if (!ok) exp_err = 1'b1;
        cycle(1'b1, corrupt ? (cks ^ 8'h01) : cks, tick_on_ck);
        chk_state("ck_state", ok ? 4'h8 : 4'h1);
    endtask

    // Sit in PENDING with junk traffic for n cycles, then tick and commit
    task automatic commit_wait(input int n);
        for (int i = 0; i < n; i++) begin
            config_en_i = 1'($urandom);
            cycle(1'($urandom), ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom), 1'b0);
            chk_state("pend_state", 4'h8);
        end
        config_en_i = 1'b1;
        m_coef   = f_coef;
        m_period = f_period;
        m_min    = f_min;
        exp_commit = 1'b1;
        cycle(1'b0, 8'h00, 1'b1);
        chk_state("commit_state", 4'h1);
        exp_commit = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic rand_coef();
        for (int c = 0; c < 5; c++) begin
            for (int b = 0; b < 4; b++) begin
                f_coef[c][8 * b +: 8] = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
            end
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        config_en_i = 1'b0;
        strb        = 1'b0;
        data_i      = 8'h00;
        update_en_i = 1'b0;
        model_reset();
        #2;
        chk_outputs();
        chk_state("reset_state", 4'h1);
        @(negedge clk_i);
        rst_i       = 1'b0;
        config_en_i = 1'b1;

        // Reference frame with a bad checksum: rejected, outputs stay at reset values
        for (int i = 0; i < 5; i++) f_coef[i] = 32'd0;
        f_coef[0] = 32'h0000_0001;
        f_coef[4] = 32'hC000_0000;
        f_period  = 9'h18F;
        f_min     = 8'h20;
        build();
        send_frame(1'b1, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // min above period with a correct checksum: rejected
        f_period = 9'h020;
        f_min    = 8'h30;
        build();
        send_frame(1'b0, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b1);

        // Valid reference frame, tick 10 cycles after PENDING
        f_period = 9'h18F;
        f_min    = 8'h20;
        build();
        send_frame(1'b0, 1'b0, acc);
        commit_wait(10);

        // Abort after payload byte 10, then a good frame clears the error
        cycle(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i <= 10; i++) cycle(1'b1, pay[i], 1'b0);
        chk_state("abort_mid", 4'h2);
        config_en_i = 1'b0;
        exp_err = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        chk_state("abort_state", 4'h1);
        config_en_i = 1'b1;
        rand_coef();
        f_period = 9'($urandom_range(0, 511));
        f_min    = 8'($urandom_range(0, (f_period > 9'd255) ? 255 : int'(f_period)));
        build();
        send_frame(1'b0, 1'b0, acc);
        commit_wait(2);

        // Tick coincident with checksum is not a commit; junk in PENDING is ignored
        rand_coef();
        f_period = 9'h1FF;
        f_min    = 8'hFF;
        build();
        send_frame(1'b0, 1'b1, acc);
        commit_wait(4);

        // Minimum-latency commit: tick on the first PENDING cycle
        rand_coef();
        f_period = 9'h000;
        f_min    = 8'h00;
        build();
        send_frame(1'b0, 1'b0, acc);
        commit_wait(0);

        // Random frames of mixed validity
        for (int n = 0; n < 12; n++) begin
            int mode;
            mode = $urandom_range(0, 3);
            rand_coef();
            if (mode == 3) begin
                f_period = 9'($urandom_range(0, 254));
                f_min    = 8'($urandom_range(int'(f_period) + 1, 255));
            end else begin
                f_period = 9'($urandom_range(0, 511));
                f_min    = 8'($urandom_range(0, (f_period > 9'd255) ? 255 : int'(f_period)));
            end
            build();
            send_frame(mode == 2, 1'($urandom), acc);
            if (acc) commit_wait($urandom_range(0, 5));
            else cycle(1'b0, 8'h00, 1'b1);
        end

        // Reset in the middle of a frame, after payload byte 15
        rand_coef();
        f_period = 9'h100;
        f_min    = 8'h80;
        build();
        exp_err = 1'b0;
        cycle(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i <= 15; i++) cycle(1'b1, pay[i], 1'b0);
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        chk_outputs();
        chk_state("midrst_state", 4'h1);
        @(negedge clk_i);
        rst_i = 1'b0;
        send_frame(1'b0, 1'b0, acc);
        commit_wait(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
